seq_gen: RTL and testbench
==========================

SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of data bits per word (legal range 2..32).
REQ-002 The block SHALL have parameter GAP, default 1, giving the number of idle bit-times after each word (legal range 0..15).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port data_in, input, WIDTH bits, the word to transmit.
REQ-006 The block SHALL have port valid, input, 1 bit, meaning data_in holds a word offered for transmission.
REQ-007 The block SHALL have port ready, output, 1 bit, meaning the block accepts a word this cycle.
REQ-008 The block SHALL have port in_ser, output, 1 bit, the serial stream that drives the sequence detector's in input.
REQ-009 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking the end of a word.

Function
REQ-011 The block SHALL implement exactly three states: IDLE, SHIFT and GAP.
REQ-012 In IDLE, the block SHALL drive ready=1, busy=0 and in_ser=0.
REQ-013 In SHIFT and GAP, the block SHALL drive ready=0.
REQ-014 A word SHALL be accepted on any rising edge with valid=1 and ready=1: data_in is captured into a shift register, the bit counter is cleared, and the state goes IDLE->SHIFT.
REQ-015 The block SHALL transmit MSB first; in_ser SHALL be registered, with data bit WIDTH-1 appearing in the cycle after acceptance and one new bit per cycle thereafter (latency 1 cycle, WIDTH cycles per word excluding parity).
REQ-016 After the last transmitted bit, the state SHALL go SHIFT->GAP when GAP>0, or SHIFT->IDLE when GAP=0.
REQ-017 GAP SHALL last exactly GAP cycles with in_ser=0, then go GAP->IDLE.
REQ-018 done SHALL be 1 for exactly one cycle: the first cycle after the last transmitted bit, whether that cycle is in GAP or in IDLE.
REQ-019 When GAP=0, back-to-back words SHALL be supported: a word accepted in the done cycle SHALL have its MSB on in_ser in the next cycle, giving WIDTH+1 cycles per word.
REQ-020 valid asserted while ready=0 SHALL be ignored and SHALL NOT disturb the word in flight; the source must hold valid until it sees ready.
REQ-021 data_in changes while ready=0 SHALL have no effect on the transmission.
REQ-022 The bit counter SHALL be sized as clog2(WIDTH+1) bits and SHALL NOT wrap during a word.

Reset
REQ-023 When rst=1 at a rising edge, the block SHALL enter IDLE and set in_ser=0, busy=0, done=0, ready=1, the shift register to 0 and both counters to 0.
REQ-024 Reset SHALL take priority over every other event, including acceptance and the final bit.
REQ-025 A word interrupted by reset SHALL be abandoned: no further bits of it, and no done pulse.
REQ-026 rst held high with valid=1 SHALL accept nothing.

Configuration
REQ-027 With macro SEQ_GEN_PARITY_EN defined, an even-parity bit (XOR of the WIDTH data bits) SHALL be transmitted as one extra bit after the LSB, before done and GAP, giving WIDTH+1 bit-times per word.
REQ-028 Without SEQ_GEN_PARITY_EN, no parity bit SHALL be transmitted and no parity logic SHALL exist.

Verification
REQ-029 Reset: rst=1 for 2 cycles with valid=1, data_in=8'hFF -> in_ser=0, ready=1, busy=0, done=0 throughout, and no bits are transmitted after reset is released.
REQ-030 Single word, WIDTH=8, GAP=1: accept 8'b1011_0010 -> in_ser = 1,0,1,1,0,0,1,0 on cycles 1..8 after acceptance; done=1 and in_ser=0 on cycle 9; ready=1 on cycle 10.
REQ-031 Busy drop: valid=1 with data_in=8'h55 on cycle 3 of the 8'hB2 word -> the 8'hB2 sequence is unchanged and 8'h55 is accepted only once ready returns.
REQ-032 Back-to-back, GAP=0: valid held high with 8'hA5 then 8'h3C -> 16 contiguous bits 1010_0101_0011_1100 with one idle cycle between the words, and two done pulses 9 cycles apart.
REQ-033 Reset mid-word: rst=1 on cycle 4 of 8'hF0 -> in_ser=0 from the next cycle, no done pulse, ready=1.
REQ-034 Parity, with SEQ_GEN_PARITY_EN defined: word 8'b0000_0111 -> data bits followed by parity bit 1 on cycle 9, done on cycle 10; word 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/seq_gen.sv
// Serial word generator: shifts each accepted word out MSB first, then holds the line idle for GAP bit-times.
// Optional even-parity bit after the LSB when SEQ_GEN_PARITY_EN is defined.
module seq_gen #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             in_ser,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

`ifdef SEQ_GEN_PARITY_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif
    localparam logic [CW-1:0] LAST_CNT = CW'(LAST);
    localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       gap_cnt;
    logic             accept;
`ifdef SEQ_GEN_PARITY_EN
    logic             par;
`endif

    assign ready  = (state == S_IDLE);
    assign busy   = (state != S_IDLE);
    assign accept = valid && ready;

    // shreg holds the bits still to send, next one in the MSB position;
    // bit_cnt is the index of the bit currently on in_ser.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            in_ser  <= 1'b0;
            done    <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        shreg   <= {data_in[WIDTH-2:0], 1'b0};
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                        in_ser  <= data_in[WIDTH-1];
                        state   <= S_SHIFT;
`ifdef SEQ_GEN_PARITY_EN
                        par     <= ^data_in;
`endif
                    end else begin
                        in_ser <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (bit_cnt == LAST_CNT) begin
                        in_ser  <= 1'b0;
                        done    <= 1'b1;
                        gap_cnt <= '0;
                        state   <= (GAP > 0) ? S_GAP : S_IDLE;
`ifdef SEQ_GEN_PARITY_EN
                    end else if (bit_cnt == CW'(WIDTH - 1)) begin
                        in_ser  <= par;
                        bit_cnt <= bit_cnt + CW'(1);
`endif
                    end else begin
                        in_ser  <= shreg[WIDTH-1];
                        shreg   <= {shreg[WIDTH-2:0], 1'b0};
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    in_ser <= 1'b0;
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    in_ser <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: one instance with GAP=1, one with GAP=0 for back-to-back traffic.
module tb_seq_gen;
`ifdef SEQ_GEN_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB = 8 + P;

    logic       clk;
    logic       rst;
    logic [7:0] data_in, data_b;
    logic       valid, valid_b;
    logic       ready, in_ser, busy, done;
    logic       ready_b, in_ser_b, busy_b, done_b;

    int nv   = 0;
    int nerr = 0;

    seq_gen #(.WIDTH(8), .GAP(1)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid(valid),
        .ready(ready), .in_ser(in_ser), .busy(busy), .done(done)
    );

    seq_gen #(.WIDTH(8), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .data_in(data_b), .valid(valid_b),
        .ready(ready_b), .in_ser(in_ser_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k < 8) return d[7-k];
        return ^d;
    endfunction

    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; data_in = 8'hFF;
        valid_b = 1'b1; data_b = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            step();
            nv++; if (in_ser !== 1'b0) begin nerr++; $display("FAIL reset_in_ser: got %b want 0", in_ser); end
            nv++; if (ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b want 1", ready); end
            nv++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
            nv++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", done); end
            nv++; if (busy_b !== 1'b0) begin nerr++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
        end
        rst = 1'b0; valid = 1'b0; valid_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            nv++; if (in_ser !== 1'b0) begin nerr++; $display("FAIL post_reset_in_ser: got %b want 0", in_ser); end
            nv++; if (busy !== 1'b0) begin nerr++; $display("FAIL post_reset_busy: got %b want 0", busy); end
            nv++; if (busy_b !== 1'b0) begin nerr++; $display("FAIL post_reset_busy_b: got %b want 0", busy_b); end
        end
    endtask

    task automatic test_single();
        logic [7:0] d;
        d = 8'b1011_0010;
        valid = 1'b1; data_in = d;
        step();
        valid = 1'b0;
        for (int k = 0; k < NB; k++) begin
            nv++; if (in_ser !== exp_bit(d, k)) begin nerr++; $display("FAIL single_bit%0d: got %b want %b", k, in_ser, exp_bit(d, k)); end
            nv++; if (ready !== 1'b0) begin nerr++; $display("FAIL single_ready%0d: got %b want 0", k, ready); end
            nv++; if (done !== 1'b0) begin nerr++; $display("FAIL single_done_early%0d: got %b want 0", k, done); end
            step();
        end
        nv++; if (done !== 1'b1) begin nerr++; $display("FAIL single_done: got %b want 1", done); end
        nv++; if (in_ser !== 1'b0) begin nerr++; $display("FAIL single_gap_in_ser: got %b want 0", in_ser); end
        nv++; if (ready !== 1'b0) begin nerr++; $display("FAIL single_gap_ready: got %b want 0", ready); end
        step();
        nv++; if (ready !== 1'b1) begin nerr++; $display("FAIL single_ready_back: got %b want 1", ready); end
        nv++; if (done !== 1'b0) begin nerr++; $display("FAIL single_done_pulse: got %b want 0", done); end
        nv++; if (busy !== 1'b0) begin nerr++; $display("FAIL single_busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_busy_drop();
        logic [7:0] d, d2;
        d = 8'hB2; d2 = 8'h55;
        valid = 1'b1; data_in = d;
        step();
        valid = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (k == 2) begin valid = 1'b1; data_in = d2; end
            nv++; if (in_ser !== exp_bit(d, k)) begin nerr++; $display("FAIL drop_bit%0d: got %b want %b", k, in_ser, exp_bit(d, k)); end
            step();
        end
        nv++; if (done !== 1'b1) begin nerr++; $display("FAIL drop_done: got %b want 1", done); end
        nv++; if (ready !== 1'b0) begin nerr++; $display("FAIL drop_gap_ready: got %b want 0", ready); end
        step();
        nv++; if (ready !== 1'b1) begin nerr++; $display("FAIL drop_ready_back: got %b want 1", ready); end
        nv++; if (in_ser !== 1'b0) begin nerr++; $display("FAIL drop_idle_in_ser: got %b want 0", in_ser); end
        step();
        valid = 1'b0;
        for (int k = 0; k < NB; k++) begin
            nv++; if (in_ser !== exp_bit(d2, k)) begin nerr++; $display("FAIL drop2_bit%0d: got %b want %b", k, in_ser, exp_bit(d2, k)); end
            step();
        end
        nv++; if (done !== 1'b1) begin nerr++; $display("FAIL drop2_done: got %b want 1", done); end
        step();
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b;
        int gap;
        a = 8'hA5; b = 8'h3C;
        valid_b = 1'b1; data_b = a;
        step();
        data_b = b;
        for (int k = 0; k < NB; k++) begin
            nv++; if (in_ser_b !== exp_bit(a, k)) begin nerr++; $display("FAIL b2b_a_bit%0d: got %b want %b", k, in_ser_b, exp_bit(a, k)); end
            step();
        end
        nv++; if (done_b !== 1'b1) begin nerr++; $display("FAIL b2b_done1: got %b want 1", done_b); end
        nv++; if (in_ser_b !== 1'b0) begin nerr++; $display("FAIL b2b_idle_in_ser: got %b want 0", in_ser_b); end
        nv++; if (ready_b !== 1'b1) begin nerr++; $display("FAIL b2b_ready: got %b want 1", ready_b); end
        step();
        gap = 1;
        valid_b = 1'b0;
        for (int k = 0; k < NB; k++) begin
            nv++; if (in_ser_b !== exp_bit(b, k)) begin nerr++; $display("FAIL b2b_b_bit%0d: got %b want %b", k, in_ser_b, exp_bit(b, k)); end
            nv++; if (done_b !== 1'b0) begin nerr++; $display("FAIL b2b_done_mid%0d: got %b want 0", k, done_b); end
            step();
            gap++;
        end
        nv++; if (done_b !== 1'b1) begin nerr++; $display("FAIL b2b_done2: got %b want 1", done_b); end
        nv++; if (gap !== NB + 1) begin nerr++; $display("FAIL b2b_done_spacing: got %0d want %0d", gap, NB + 1); end
        step();
        nv++; if (busy_b !== 1'b0) begin nerr++; $display("FAIL b2b_busy_end: got %b want 0", busy_b); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'hF0;
        valid = 1'b1; data_in = d;
        step();
        valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            nv++; if (in_ser !== exp_bit(d, k)) begin nerr++; $display("FAIL rmid_bit%0d: got %b want %b", k, in_ser, exp_bit(d, k)); end
            if (k == 3) rst = 1'b1;
            step();
        end
        nv++; if (in_ser !== 1'b0) begin nerr++; $display("FAIL rmid_in_ser: got %b want 0", in_ser); end
        nv++; if (ready !== 1'b1) begin nerr++; $display("FAIL rmid_ready: got %b want 1", ready); end
        nv++; if (busy !== 1'b0) begin nerr++; $display("FAIL rmid_busy: got %b want 0", busy); end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            nv++; if (done !== 1'b0) begin nerr++; $display("FAIL rmid_no_done%0d: got %b want 0", i, done); end
            nv++; if (in_ser !== 1'b0) begin nerr++; $display("FAIL rmid_quiet%0d: got %b want 0", i, in_ser); end
            step();
        end
    endtask

`ifdef SEQ_GEN_PARITY_EN
    task automatic test_parity();
        logic [7:0] words [2];
        logic       pexp  [2];
        words[0] = 8'b0000_0111; pexp[0] = 1'b1;
        words[1] = 8'h03;        pexp[1] = 1'b0;
        for (int w = 0; w < 2; w++) begin
            valid = 1'b1; data_in = words[w];
            step();
            valid = 1'b0;
            for (int k = 0; k < 8; k++) begin
                nv++; if (in_ser !== words[w][7-k]) begin nerr++; $display("FAIL par%0d_bit%0d: got %b want %b", w, k, in_ser, words[w][7-k]); end
                step();
            end
            nv++; if (in_ser !== pexp[w]) begin nerr++; $display("FAIL par%0d_parity: got %b want %b", w, in_ser, pexp[w]); end
            nv++; if (done !== 1'b0) begin nerr++; $display("FAIL par%0d_done_early: got %b want 0", w, done); end
            step();
            nv++; if (done !== 1'b1) begin nerr++; $display("FAIL par%0d_done: got %b want 1", w, done); end
            step();
            step();
        end
    endtask
`endif

    initial begin
        rst = 1'b1; valid = 1'b0; data_in = '0; valid_b = 1'b0; data_b = '0;
        test_reset();
        test_single();
        test_busy_drop();
        test_back_to_back();
        test_reset_mid();
`ifdef SEQ_GEN_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
        $finish;
    end
endmodule
